cordic_preprocess: RTL and testbench

CORDIC_PREPROCESS -- requirements
Module: cordic_preprocess

---
 rtl/cordic_preprocess.sv | 99 +++++++++
 tb/tb_cordic_preprocess.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_preprocess.sv
// CORDIC front end: folds a binary-angle phase into [-90, +90) degrees and presents
// the initial vector (1/K, 0), residual angle, negate flag and sample tag downstream.
module cordic_preprocess #(
  parameter logic [31:0] X_INIT = 32'h26DD3B6A,
  parameter int unsigned TAG_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      phase_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      x_out,
  output logic [31:0]      y_out,
  output logic [31:0]      z_out,
  output logic             neg_out,
  output logic [TAG_W-1:0] tag_out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [TAG_W-1:0] TagOne  = TAG_W'(1);
  localparam logic [31:0]      HalfTurn = 32'h8000_0000;

  logic             r_s1_valid;
  logic [31:0]      r_s1_z;
  logic             r_s1_neg;
  logic [TAG_W-1:0] r_s1_tag;
  logic [TAG_W-1:0] r_tag_cnt;

  logic             r_out_valid;
  logic [31:0]      r_x;
  logic [31:0]      r_z;
  logic             r_neg;
  logic [TAG_W-1:0] r_tag;

  logic             w_s2_load;
  logic             w_s1_load;
  logic             w_in_fire;
  logic             w_fold_neg;
  logic [31:0]      w_fold_z;

  assign w_s2_load = !r_out_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = w_s1_load;
  assign w_in_fire = in_valid && w_s1_load;

  // Quadrants 1 and 2 rotate by half a turn; the final vector is then negated downstream.
  assign w_fold_neg = phase_in[31] ^ phase_in[30];
  assign w_fold_z   = w_fold_neg ? (phase_in + HalfTurn) : phase_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_z     <= '0;
      r_s1_neg   <= 1'b0;
      r_s1_tag   <= '0;
      r_tag_cnt  <= '0;
    end else begin
      if (w_s1_load) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_z   <= w_fold_z;
          r_s1_neg <= w_fold_neg;
          r_s1_tag <= r_tag_cnt;
        end
      end
      if (w_in_fire) begin
        r_tag_cnt <= r_tag_cnt + TagOne;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_x         <= '0;
      r_z         <= '0;
      r_neg       <= 1'b0;
      r_tag       <= '0;
    end else if (w_s2_load) begin
      r_out_valid <= r_s1_valid;
      // Data only moves with a valid sample, so a stalled or bubbled output stays put.
      if (r_s1_valid) begin
        r_x   <= X_INIT;
        r_z   <= r_s1_z;
        r_neg <= r_s1_neg;
        r_tag <= r_s1_tag;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign x_out     = r_x;
  assign y_out     = '0;
  assign z_out     = r_z;
  assign neg_out   = r_neg;
  assign tag_out   = r_tag;

endmodule

// File: tb/tb_cordic_preprocess.sv
// Randomised self-checking bench for cordic_preprocess with a queue-based angle-fold model.
module tb_cordic_preprocess;

  localparam logic [31:0] XInit = 32'h26DD3B6A;

  typedef struct packed {
    logic [31:0] z;
    logic        neg;
    logic [7:0]  tag;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] phase_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x_out;
  logic [31:0] y_out;
  logic [31:0] z_out;
  logic        neg_out;
  logic [7:0]  tag_out;
  logic        out_valid;
  logic        out_ready;

  int unsigned n_checks;
  int unsigned n_pass;
  exp_t        q[$];
  logic [7:0]  tag_m;

  // Snapshot of DUT outputs taken by step() just before the active edge.
  logic        s_ov, s_ir, s_neg;
  logic [31:0] s_x, s_y, s_z;
  logic [7:0]  s_tag;

  cordic_preprocess #(
    .X_INIT(XInit),
    .TAG_W (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .phase_in (phase_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_out    (x_out),
    .y_out    (y_out),
    .z_out    (z_out),
    .neg_out  (neg_out),
    .tag_out  (tag_out),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Angles in [90, 270) degrees are rotated by 180 degrees and flagged for negation.
  function automatic exp_t model(input logic [31:0] ph, input logic [7:0] tag);
    longint unsigned p;
    exp_t e;
    p = 64'(ph);
    e.tag = tag;
    if (p >= 64'h4000_0000 && p < 64'hC000_0000) begin
      e.neg = 1'b1;
      e.z   = 32'((p + 64'h8000_0000) % 64'h1_0000_0000);
    end else begin
      e.neg = 1'b0;
      e.z   = ph;
    end
    return e;
  endfunction

  task automatic step(input logic iv, input logic [31:0] ph, input logic ordy,
                      output logic fin, output logic fout);
    @(negedge clk);
    in_valid  = iv;
    phase_in  = ph;
    out_ready = ordy;
    #1;
    s_ov  = out_valid;
    s_ir  = in_ready;
    s_x   = x_out;
    s_y   = y_out;
    s_z   = z_out;
    s_neg = neg_out;
    s_tag = tag_out;
    fin   = iv && in_ready;
    fout  = out_valid && ordy;
    if (fin) begin
      q.push_back(model(ph, tag_m));
      tag_m = tag_m + 8'd1;
    end
    @(posedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    q.delete();
    tag_m = 8'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (x_out !== 32'd0) $display("FAIL reset_x: got %h want 0", x_out); else n_pass++;
    n_checks++; if (y_out !== 32'd0) $display("FAIL reset_y: got %h want 0", y_out); else n_pass++;
    n_checks++; if (z_out !== 32'd0) $display("FAIL reset_z: got %h want 0", z_out); else n_pass++;
    n_checks++; if (neg_out !== 1'b0) $display("FAIL reset_neg: got %b want 0", neg_out); else n_pass++;
    n_checks++; if (tag_out !== 8'd0) $display("FAIL reset_tag: got %h want 0", tag_out); else n_pass++;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
  endtask

  task automatic test_single();
    logic fin, fout;
    exp_t e;
    step(1'b1, 32'h2000_0000, 1'b1, fin, fout);
    step(1'b0, 32'd0, 1'b1, fin, fout);
    n_checks++; if (s_ov !== 1'b0) $display("FAIL single_early: got out_valid %b want 0", s_ov); else n_pass++;
    step(1'b0, 32'd0, 1'b1, fin, fout);
    n_checks++; if (s_ov !== 1'b1) $display("FAIL single_valid: got %b want 1", s_ov); else n_pass++;
    n_checks++; if (s_z !== 32'h2000_0000) $display("FAIL single_z: got %h want 20000000", s_z); else n_pass++;
    n_checks++; if (s_neg !== 1'b0) $display("FAIL single_neg: got %b want 0", s_neg); else n_pass++;
    n_checks++; if (s_x !== 32'h26DD3B6A) $display("FAIL single_x: got %h want 26dd3b6a", s_x); else n_pass++;
    n_checks++; if (s_y !== 32'd0) $display("FAIL single_y: got %h want 0", s_y); else n_pass++;
    n_checks++; if (s_tag !== 8'd0) $display("FAIL single_tag: got %h want 0", s_tag); else n_pass++;
    if (fout && q.size() > 0) e = q.pop_front();
  endtask

  task automatic test_fold();
    logic [31:0] ph [8];
    logic [31:0] lit_z [3];
    logic        lit_neg [3];
    logic fin, fout;
    int i, k, cyc;
    exp_t e;
    ph[0] = 32'h4000_0000; lit_z[0] = 32'hC000_0000; lit_neg[0] = 1'b1;
    ph[1] = 32'h8000_0000; lit_z[1] = 32'h0000_0000; lit_neg[1] = 1'b1;
    ph[2] = 32'hC000_0000; lit_z[2] = 32'hC000_0000; lit_neg[2] = 1'b0;
    ph[3] = 32'h3FFF_FFFF;
    ph[4] = 32'hBFFF_FFFF;
    for (int j = 5; j < 8; j++) ph[j] = $urandom;
    i = 0; k = 0; cyc = 0;
    while ((i < 8 || q.size() > 0) && cyc < 40) begin
      step(i < 8, (i < 8) ? ph[i] : 32'd0, 1'b1, fin, fout);
      if (fin) i++;
      if (fout) begin
        e = q.pop_front();
        n_checks++; if (s_z !== e.z) $display("FAIL fold_z[%0d]: got %h want %h", k, s_z, e.z); else n_pass++;
        n_checks++; if (s_neg !== e.neg) $display("FAIL fold_neg[%0d]: got %b want %b", k, s_neg, e.neg); else n_pass++;
        n_checks++; if (s_tag !== e.tag) $display("FAIL fold_tag[%0d]: got %h want %h", k, s_tag, e.tag); else n_pass++;
        if (k < 3) begin
          n_checks++; if (s_z !== lit_z[k]) $display("FAIL fold_lit_z[%0d]: got %h want %h", k, s_z, lit_z[k]); else n_pass++;
          n_checks++; if (s_neg !== lit_neg[k]) $display("FAIL fold_lit_neg[%0d]: got %b want %b", k, s_neg, lit_neg[k]); else n_pass++;
        end
        k++;
      end
      cyc++;
    end
    n_checks++; if (k !== 8) $display("FAIL fold_count: got %0d want 8", k); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic fin, fout;
    int i, k, gaps, cyc;
    logic [7:0] want_tag;
    exp_t e;
    apply_reset();
    i = 0; k = 0; gaps = 0; cyc = 0;
    while ((i < 300 || q.size() > 0) && cyc < 400) begin
      step(i < 300, $urandom, 1'b1, fin, fout);
      if (fin) i++;
      if (fout) begin
        e = q.pop_front();
        want_tag = 8'(k % 256);
        n_checks++; if (s_tag !== want_tag) $display("FAIL b2b_tag[%0d]: got %h want %h", k, s_tag, want_tag); else n_pass++;
        n_checks++; if (s_z !== e.z || s_neg !== e.neg) $display("FAIL b2b_data[%0d]: got %h/%b want %h/%b", k, s_z, s_neg, e.z, e.neg); else n_pass++;
        k++;
      end else if (k > 0 && k < 300) begin
        gaps++;
      end
      cyc++;
    end
    n_checks++; if (k !== 300) $display("FAIL b2b_count: got %0d want 300", k); else n_pass++;
    n_checks++; if (gaps !== 0) $display("FAIL b2b_gaps: got %0d want 0", gaps); else n_pass++;
  endtask

  task automatic test_stall();
    logic fin, fout;
    int i, accepts, k, cyc;
    logic have;
    logic [31:0] hz;
    logic        hneg;
    logic [7:0]  htag;
    exp_t e;
    apply_reset();
    i = 0; accepts = 0; have = 1'b0;
    hz = '0; hneg = 1'b0; htag = '0;
    for (int c = 0; c < 7; c++) begin
      step(1'b1, 32'h1000_0000 + 32'(i) * 32'h4000_0000, 1'b0, fin, fout);
      if (fin) begin i++; accepts++; end
      if (s_ov) begin
        if (!have) begin
          have = 1'b1; hz = s_z; hneg = s_neg; htag = s_tag;
        end else begin
          n_checks++;
          if (s_z !== hz || s_neg !== hneg || s_tag !== htag)
            $display("FAIL stall_stable: got %h/%b/%h want %h/%b/%h", s_z, s_neg, s_tag, hz, hneg, htag);
          else n_pass++;
        end
      end
    end
    n_checks++; if (accepts !== 2) $display("FAIL stall_accepts: got %0d want 2", accepts); else n_pass++;
    n_checks++; if (s_ir !== 1'b0) $display("FAIL stall_in_ready: got %b want 0", s_ir); else n_pass++;
    k = 0; cyc = 0;
    while (q.size() > 0 && cyc < 10) begin
      step(1'b0, 32'd0, 1'b1, fin, fout);
      if (fout) begin
        e = q.pop_front();
        n_checks++; if (s_tag !== 8'(k)) $display("FAIL stall_drain_tag[%0d]: got %h want %h", k, s_tag, 8'(k)); else n_pass++;
        n_checks++; if (s_z !== e.z || s_neg !== e.neg) $display("FAIL stall_drain_data[%0d]: got %h/%b want %h/%b", k, s_z, s_neg, e.z, e.neg); else n_pass++;
        k++;
      end
      cyc++;
    end
    n_checks++; if (k !== 2) $display("FAIL stall_drain_count: got %0d want 2", k); else n_pass++;
    step(1'b0, 32'd0, 1'b1, fin, fout);
    n_checks++; if (s_ir !== 1'b1) $display("FAIL stall_ready_after: got %b want 1", s_ir); else n_pass++;
    n_checks++; if (s_ov !== 1'b0) $display("FAIL stall_empty_after: got %b want 0", s_ov); else n_pass++;
  endtask

  task automatic test_random();
    logic fin, fout, iv, ordy, prev_stall;
    logic [31:0] pz;
    logic        pneg;
    logic [7:0]  ptag;
    int sent, got, cyc;
    exp_t e;
    sent = 0; got = 0; cyc = 0; prev_stall = 1'b0;
    pz = '0; pneg = 1'b0; ptag = '0;
    while ((sent < 10000 || q.size() > 0) && cyc < 60000) begin
      iv   = (sent < 10000) ? 1'($urandom % 2) : 1'b0;
      ordy = 1'($urandom % 2);
      step(iv, $urandom, ordy, fin, fout);
      if (fin) sent++;
      if (prev_stall) begin
        n_checks++;
        if (s_ov !== 1'b1 || s_z !== pz || s_neg !== pneg || s_tag !== ptag)
          $display("FAIL rand_stable: got %b/%h/%b/%h want 1/%h/%b/%h", s_ov, s_z, s_neg, s_tag, pz, pneg, ptag);
        else n_pass++;
      end
      if (fout) begin
        if (q.size() == 0) begin
          n_checks++;
          $display("FAIL rand_extra: got unexpected output tag %h want none", s_tag);
        end else begin
          e = q.pop_front();
          n_checks++; if (s_z !== e.z) $display("FAIL rand_z[%0d]: got %h want %h", got, s_z, e.z); else n_pass++;
          n_checks++; if (s_neg !== e.neg) $display("FAIL rand_neg[%0d]: got %b want %b", got, s_neg, e.neg); else n_pass++;
          n_checks++; if (s_tag !== e.tag) $display("FAIL rand_tag[%0d]: got %h want %h", got, s_tag, e.tag); else n_pass++;
          n_checks++; if (s_x !== XInit || s_y !== 32'd0) $display("FAIL rand_xy[%0d]: got %h/%h want %h/0", got, s_x, s_y, XInit); else n_pass++;
          n_checks++;
          if ($signed(s_z) < -32'sh4000_0000 || $signed(s_z) >= 32'sh4000_0000)
            $display("FAIL rand_range[%0d]: got %h want within [-2^30,2^30)", got, s_z);
          else n_pass++;
        end
        got++;
      end
      prev_stall = s_ov && !ordy;
      pz = s_z; pneg = s_neg; ptag = s_tag;
      cyc++;
    end
    n_checks++; if (got !== 10000) $display("FAIL rand_count: got %0d want 10000", got); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic fin, fout;
    exp_t e;
    step(1'b1, 32'h1111_1111, 1'b0, fin, fout);
    step(1'b1, 32'h5555_5555, 1'b0, fin, fout);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL mid_reset_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (tag_out !== 8'd0 || z_out !== 32'd0) $display("FAIL mid_reset_out: got %h/%h want 0/0", tag_out, z_out); else n_pass++;
    q.delete();
    tag_m = 8'd0;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'hA000_0000, 1'b1, fin, fout);
    step(1'b0, 32'd0, 1'b1, fin, fout);
    n_checks++; if (s_ov !== 1'b0) $display("FAIL mid_stale: got out_valid %b want 0", s_ov); else n_pass++;
    step(1'b0, 32'd0, 1'b1, fin, fout);
    n_checks++; if (s_ov !== 1'b1) $display("FAIL mid_new_valid: got %b want 1", s_ov); else n_pass++;
    n_checks++; if (s_tag !== 8'd0) $display("FAIL mid_new_tag: got %h want 0", s_tag); else n_pass++;
    n_checks++; if (s_z !== 32'h2000_0000 || s_neg !== 1'b1) $display("FAIL mid_new_data: got %h/%b want 20000000/1", s_z, s_neg); else n_pass++;
    if (fout && q.size() > 0) e = q.pop_front();
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; phase_in = '0;
    n_checks = 0; n_pass = 0; tag_m = 8'd0;
    test_reset();
    test_single();
    test_fold();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
